// File: rtl/hex_display_ctrl.sv
// Four-digit 7-segment controller: one shared nibble decoder fills a shadow
// buffer digit by digit, then all four digits commit to the outputs together.
module hex_display_ctrl #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank,
    output logic        busy,
    output logic        done,
    output logic        ovr,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;

    state_t           state, state_d;
    logic [15:0]      shadow, pend;
    logic             pend_v;
    logic [1:0]       idx;
    logic [3:0][6:0]  buff;
    logic [3:0][6:0]  hexr;
    logic [3:0]       nib;
    logic             load_wr, load_pend, to_pend, ovr_d, commit;
    logic             lz1, lz2, lz3;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h18;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h27;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
    endfunction

    assign nib = shadow[{idx, 2'b00} +: 4];

    // Leading-zero blanking is cumulative from the top digit down; HEX0 always shows.
    assign lz3 = LZ_BLANK && (shadow[15:12] == 4'h0);
    assign lz2 = lz3 && (shadow[11:8] == 4'h0);
    assign lz1 = lz2 && (shadow[7:4] == 4'h0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load_wr   = 1'b0;
        load_pend = 1'b0;
        to_pend   = 1'b0;
        ovr_d     = 1'b0;
        commit    = 1'b0;
        if (blank) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        load_wr = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (wr_en) begin
                        to_pend = 1'b1;
                        ovr_d   = pend_v;
                    end
                    if (idx == 2'd3) state_d = COMMIT;
                end
                COMMIT: begin
                    commit = 1'b1;
                    if (wr_en) begin
                        // A fresh write supersedes any pending value.
                        load_wr = 1'b1;
                        ovr_d   = pend_v;
                        state_d = DECODE;
                    end else if (pend_v) begin
                        load_pend = 1'b1;
                        state_d   = DECODE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= 16'h0;
            pend   <= 16'h0;
            pend_v <= 1'b0;
            idx    <= 2'd0;
            buff   <= {4{SEG_OFF}};
            hexr   <= {4{SEG_OFF}};
            done   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            done <= commit;
            ovr  <= ovr_d;
            if (blank) begin
                hexr   <= {4{SEG_OFF}};
                pend_v <= 1'b0;
                idx    <= 2'd0;
            end else begin
                if (state == DECODE) begin
                    buff[idx] <= seg(nib);
                    idx       <= idx + 2'd1;
                end
                if (to_pend) begin
                    pend   <= wr_data;
                    pend_v <= 1'b1;
                end
                if (load_wr || load_pend) begin
                    shadow <= load_wr ? wr_data : pend;
                    idx    <= 2'd0;
                    pend_v <= 1'b0;
                end
                if (commit) begin
                    hexr[3] <= lz3 ? SEG_OFF : buff[3];
                    hexr[2] <= lz2 ? SEG_OFF : buff[2];
                    hexr[1] <= lz1 ? SEG_OFF : buff[1];
                    hexr[0] <= buff[0];
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign hex0 = hexr[0];
    assign hex1 = hexr[1];
    assign hex2 = hexr[2];
    assign hex3 = hexr[3];
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench: stimulus pushes expected commits (digits + commit cycle);
// a monitor pops and compares on every done pulse.
module tb_hex_display_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0, wr_en0 = 1'b0;
    logic [15:0] wr_data = 16'h0, wr_data0 = 16'h0;
    logic        blank = 1'b0, blank0 = 1'b0;
    logic        busy, done, ovr, busy0, done0, ovr0;
    logic [6:0]  hex0, hex1, hex2, hex3, h0_0, h1_0, h2_0, h3_0;

    typedef struct {
        logic [27:0] hex;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ovr_cnt = 0;
    int   c;

    hex_display_ctrl #(.LZ_BLANK(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .blank(blank),
        .busy(busy), .done(done), .ovr(ovr),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3));

    hex_display_ctrl #(.LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en0), .wr_data(wr_data0), .blank(blank0),
        .busy(busy0), .done(done0), .ovr(ovr0),
        .hex0(h0_0), .hex1(h1_0), .hex2(h2_0), .hex3(h3_0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] h4(input logic [6:0] a3, a2, a1, a0);
        h4 = {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push(input logic [27:0] h, input int at);
        exp_t e;
        e.hex = h;
        e.cyc = at;
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ovr === 1'b1) ovr_cnt++;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("commit hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, e.hex});
                    chk("commit cycle", cyc, e.cyc);
                end
            end
            if (done0 === 1'b1) begin
                if (q0.size() == 0) begin
                    chk("unexpected done0", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("commit hex nolz", {4'h0, h3_0, h2_0, h1_0, h0_0}, {4'h0, e.hex});
                    chk("commit cycle nolz", cyc, e.cyc);
                end
            end
        end
    endtask

    initial begin
        exp_t e0;
        fork
            monitor();
        join_none

        // Reset state
        #12;
        chk("reset hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, h4(7'h7F, 7'h7F, 7'h7F, 7'h7F)});
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset ovr", ovr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Leading-zero blanking on both variants
        c = cyc;
        push(h4(7'h7F, 7'h7F, 7'h7F, 7'h12), c + 6);
        e0.hex = h4(7'h40, 7'h40, 7'h40, 7'h12);
        e0.cyc = c + 6;
        q0.push_back(e0);
        wr_en0 = 1'b1;
        wr_data0 = 16'h0005;
        wr(16'h0005);
        wr_en0 = 1'b0;
        chk("busy after accept", busy, 1);
        repeat (6) tick();
        chk("busy after commit", busy, 0);

        c = cyc;
        push(h4(7'h7F, 7'h7F, 7'h7F, 7'h40), c + 6);
        wr(16'h0000);
        repeat (6) tick();

        c = cyc;
        push(h4(7'h7F, 7'h0E, 7'h40, 7'h40), c + 6);
        wr(16'h0F00);
        repeat (6) tick();

        // Pending overwrite: 0x1111 lost, 0x2222 follows
        ovr_cnt = 0;
        c = cyc;
        push(h4(7'h08, 7'h03, 7'h27, 7'h21), c + 6);
        push(h4(7'h24, 7'h24, 7'h24, 7'h24), c + 11);
        wr(16'hABCD);
        tick();
        wr(16'h1111);
        wr(16'h2222);
        repeat (10) tick();
        chk("pending ovr count", ovr_cnt, 1);

        // Write landing in the COMMIT cycle
        ovr_cnt = 0;
        c = cyc;
        push(h4(7'h7F, 7'h7F, 7'h0E, 7'h0E), c + 6);
        push(h4(7'h00, 7'h06, 7'h40, 7'h40), c + 11);
        wr(16'h00FF);
        repeat (4) tick();
        wr(16'h8E00);
        repeat (8) tick();
        chk("commit-write ovr count", ovr_cnt, 0);

        // Asynchronous reset mid-DECODE
        wr(16'h9999);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, h4(7'h7F, 7'h7F, 7'h7F, 7'h7F)});
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        c = cyc;
        push(h4(7'h79, 7'h24, 7'h30, 7'h19), c + 6);
        wr(16'h1234);
        repeat (8) tick();

        // Blank mid-sequence with a simultaneous write
        wr(16'h1234);
        tick();
        blank   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h5678;
        tick();
        blank   = 1'b0;
        wr_en   = 1'b0;
        chk("blank hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, h4(7'h7F, 7'h7F, 7'h7F, 7'h7F)});
        chk("blank busy", busy, 0);
        repeat (8) tick();
        chk("busy after blank", busy, 0);
        chk("hex stays blank", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, h4(7'h7F, 7'h7F, 7'h7F, 7'h7F)});

        chk("scoreboard drained", q.size(), 0);
        chk("scoreboard nolz drained", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Sequencing controller for the board's four 7-segment displays (HEX3..HEX0). It accepts a 16-bit value through a write strobe from the memory-mapped I/O path and time-shares a single nibble-to-segment decoder across the four digits, one digit per cycle, into a shadow buffer. It then commits all four digits to the display outputs in the same cycle, with optional leading-zero blanking. A one-deep pending register absorbs writes that arrive while a sequence is in flight.

## Interface
- `LZ_BLANK`, default 1: when 1, leading zero digits (HEX3 down to HEX1) are blanked; HEX0 is never blanked.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe; `wr_data` is sampled on any edge where it is high.
- `wr_data` in 16: value to display; nibble k drives HEXk.
- `blank` in 1: synchronous clear; blanks all digits and aborts any in-flight sequence.
- `busy` out 1: high while a sequence is in progress (state other than IDLE).
- `done` out 1: one-cycle pulse, high in the cycle after a commit edge.
- `ovr` out 1: one-cycle pulse when a valid pending value is overwritten.
- `hex0`..`hex3` out 7 each: active-low segments; bit6 = g ... bit0 = a.

## Operation
- Registers:
  - `shadow[15:0]`: value being decoded.
  - `idx[1:0]`: digit counter.
  - `buf0..buf3[6:0]`: decoded digits, not yet displayed.
  - `pend[15:0]` and `pend_v`: pending write.
  - `state`.
- Decoder: one combinational nibble-to-segment function, shared by all digits. Encodings (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, b=03, c=27, d=21, E=06, F=0E (all hex)
- Blank code is 7'h7F.
- FSM states: IDLE, DECODE, COMMIT.
- IDLE:
  - On `wr_en`: `shadow` <= `wr_data`, `idx` <= 0, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Each edge: `buf[idx]` <= dec(`shadow[4*idx+3:4*idx]`), `idx` <= `idx`+1.
  - After writing buf3 (`idx`==3), go to COMMIT.
- COMMIT edge:
  - `hexk` <= `bufk` for all k simultaneously.
  - If `LZ_BLANK`=1, blanking is applied at commit. HEX3 is blanked if nibble3==0. HEX2 is blanked if nibbles 3..2 == 0. HEX1 is blanked if nibbles 3..1 == 0. The blanking decision uses `shadow`.
  - `done` <= 1.
  - Next state:
    - If `wr_en` is high this cycle: `shadow` <= `wr_data`, clear `pend_v`, go to DECODE.
    - Else if `pend_v`: `shadow` <= `pend`, clear `pend_v`, go to DECODE.
    - Else go to IDLE.
- `wr_en` while in DECODE:
  - `pend` <= `wr_data`, `pend_v` <= 1 (newest value wins).
  - If `pend_v` was already 1, pulse `ovr`.
- `wr_en` in COMMIT when `pend_v`=1: the pending value is discarded and `ovr` pulses.
- `blank` has priority over everything. On an edge where `blank`=1:
  - all `hexk` <= 7'h7F, state <= IDLE, `pend_v` <= 0.
  - `done` and `ovr` stay 0; any `wr_en` in the same cycle is ignored.
- Reset values: all `hexk` = 7'h7F, `busy`=0, `done`=0, `ovr`=0, `pend_v`=0, state=IDLE, `idx`=0, `buf` = 7'h7F.

## Timing
- Accept edge E0 (IDLE, `wr_en`=1). buf0..buf3 are written at E1..E4. Outputs update at E5.
- Commit latency is 5 edges.
- `done` is high between E5 and E6.
- `busy` is high from after E0 until after E5 when nothing follows.
- Back-to-back writes (pending or write-at-COMMIT) restart at DECODE with no IDLE cycle. The next commit is at E10.
- Sustained throughput: one value per 5 cycles.
- `hexk` never shows a partially decoded value; all four change on the same edge.
- Reset asserted mid-sequence clears outputs immediately (asynchronously). After deassertion the block is in IDLE and the interrupted value is lost.

## Test plan
- Reset: assert `reset_n`=0 mid-DECODE. Required: `hex0..3` = 7F immediately, `busy`=0, `done`=0. After release, `wr_en` with 0x1234 gives hex3..0 = 79,24,30,19 exactly 5 edges later, with a single `done` pulse.
- Leading-zero blanking, `LZ_BLANK`=1:
  - 0x0005 gives hex3..0 = 7F,7F,7F,12.
  - 0x0000 gives 7F,7F,7F,40.
  - 0x0F00 gives 7F,0E,40,40.
- Leading-zero blanking, `LZ_BLANK`=0: 0x0005 gives hex3..0 = 40,40,40,12.
- Pending: write 0xABCD at E0, 0x1111 at E2, 0x2222 at E3.
  - `ovr` pulses once, after E3.
  - Commit at E5 shows b,A... wait order hex3..0 = 08,03,27,21.
  - Commit at E10 shows 0x2222 = 24,24,24,24; 0x1111 is never displayed.
- Write at COMMIT: write 0x00FF at E0 and 0x8E00 at E4 (the COMMIT cycle).
  - E5 shows 7F,7F,0E,0E.
  - E10 shows 00,06,40,40.
  - `ovr` never pulses.
- `blank`: assert `blank` at E2 of a 0x1234 sequence, together with `wr_en`.
  - All `hex` = 7F after E2, `busy`=0.
  - No `done` pulse and no commit follow.
  - `wr_en` in that cycle is dropped.
